// File: rtl/mem_miss_arbiter_if.sv
// Bundle between the miss arbiter, both caches and main memory.
// slave  : the arbiter (takes cache requests and memory read data)
// master : the cache/memory side that drives those requests
interface mem_miss_arbiter_if;
   logic        i_miss;
   logic [15:0] i_addr;
   logic        d_miss;
   logic [15:0] d_addr;
   logic        d_wr;
   logic [15:0] d_wdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_valid;
   logic [15:0] fill_addr;
   logic [15:0] fill_data;
   logic        i_data_we;
   logic        i_tag_we;
   logic        d_data_we;
   logic        d_tag_we;
   logic        stall;

   modport slave (
      input  i_miss, i_addr, d_miss, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
      output mem_en, mem_wr, mem_addr, mem_wdata, fill_addr, fill_data,
             i_data_we, i_tag_we, d_data_we, d_tag_we, stall
   );

   modport master (
      output i_miss, i_addr, d_miss, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
      input  mem_en, mem_wr, mem_addr, mem_wdata, fill_addr, fill_data,
             i_data_we, i_tag_we, d_data_we, d_tag_we, stall
   );
endinterface

// File: rtl/mem_miss_arbiter.sv
// Single owner of main memory: arbitrates D-miss fill, D write-through store
// and I-miss fill, streams the block fill into the chosen cache and stalls
// the pipeline while memory is busy.
module mem_miss_arbiter #(
   parameter int WORDS   = 8,
   parameter int MEM_LAT = 4
) (
   input  logic            clk,
   input  logic            rst,
   mem_miss_arbiter_if.slave bus
);
   // Counters carry one extra bit so "all WORDS issued" is representable.
   localparam int          CNT_W    = $clog2(WORDS) + 1;
   localparam logic [15:0] BLK_MASK = 16'(2 * WORDS - 1);

   if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0 || MEM_LAT < 1) begin : g_bad_param
      $error("mem_miss_arbiter: WORDS must be a power of 2 >= 2 and MEM_LAT >= 1");
   end

   typedef enum logic [2:0] {IDLE, WRITE, FILL_D, FILL_I, DONE} state_t;

   state_t             state;
   logic [15:0]        base;
   logic [CNT_W-1:0]   iss_cnt;
   logic [CNT_W-1:0]   rcv_cnt;
   logic               filling;
   logic               issuing;
   logic               recv;
   logic               last;

   assign filling = (state == FILL_D) || (state == FILL_I);
   assign issuing = filling && (iss_cnt < CNT_W'(WORDS));
   // Read data is only meaningful while a fill is in progress.
   assign recv    = filling && bus.mem_valid;
   assign last    = recv && (rcv_cnt == CNT_W'(WORDS - 1));

   // Control FSM: arbitration, fill counters and latched block base.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         base    <= '0;
         iss_cnt <= '0;
         rcv_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               // A store miss fills first; the store re-issues later as a hit.
               if (bus.d_miss) begin
                  state   <= FILL_D;
                  base    <= bus.d_addr & ~BLK_MASK;
                  iss_cnt <= '0;
                  rcv_cnt <= '0;
               end else if (bus.d_wr) begin
                  state   <= WRITE;
               end else if (bus.i_miss) begin
                  state   <= FILL_I;
                  base    <= bus.i_addr & ~BLK_MASK;
                  iss_cnt <= '0;
                  rcv_cnt <= '0;
               end
            end
            WRITE: state <= DONE;
            FILL_D, FILL_I: begin
               if (issuing) iss_cnt <= iss_cnt + CNT_W'(1);
               if (recv)    rcv_cnt <= rcv_cnt + CNT_W'(1);
               if (last)    state   <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode from the registered state; stall alone looks at live requests in IDLE.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.fill_addr = '0;
      bus.fill_data = '0;
      bus.i_data_we = 1'b0;
      bus.i_tag_we  = 1'b0;
      bus.d_data_we = 1'b0;
      bus.d_tag_we  = 1'b0;
      bus.stall     = 1'b0;
      case (state)
         IDLE: bus.stall = !rst && (bus.d_miss || bus.d_wr || bus.i_miss);
         WRITE: begin
            bus.stall     = 1'b1;
            bus.mem_en    = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
         end
         FILL_D, FILL_I: begin
            bus.stall = 1'b1;
            if (issuing) begin
               bus.mem_en   = 1'b1;
               bus.mem_addr = base + 16'({iss_cnt, 1'b0});
            end
            if (recv) begin
               bus.fill_addr = base + 16'({rcv_cnt, 1'b0});
               bus.fill_data = bus.mem_rdata;
               bus.d_data_we = (state == FILL_D);
               bus.i_data_we = (state == FILL_I);
               bus.d_tag_we  = last && (state == FILL_D);
               bus.i_tag_we  = last && (state == FILL_I);
            end
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_mem_miss_arbiter.sv
// Randomized bench for mem_miss_arbiter: a latency-accurate memory model plus
// a per-transaction timeline of expected outputs derived from the block rules.
module tb_mem_miss_arbiter;
   localparam int W = 8;
   localparam int L = 4;
   localparam int N = W + L;   // cycle index of DONE, relative to the request cycle

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_miss_arbiter_if bus();

   mem_miss_arbiter #(.WORDS(W), .MEM_LAT(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit spur   = 1'b0;

   typedef struct { int due; logic [15:0] addr; } rd_t;
   rd_t         pend[$];
   logic [15:0] wmem [logic [15:0]];
   logic        cap_en, cap_wr;
   logic [15:0] cap_addr, cap_wdata;

   function automatic logic [15:0] mem_rd(input logic [15:0] a);
      if (wmem.exists(a)) return wmem[a];
      return a ^ 16'h5A5A;
   endfunction

   // Memory model: capture the request mid-cycle, answer MEM_LAT-1 cycles later.
   always @(negedge clk) begin
      cap_en    = bus.mem_en;
      cap_wr    = bus.mem_wr;
      cap_addr  = bus.mem_addr;
      cap_wdata = bus.mem_wdata;
   end

   always @(posedge clk) begin
      if (cap_en && !cap_wr) pend.push_back('{due: cyc + L - 1, addr: cap_addr});
      if (cap_en && cap_wr)  wmem[cap_addr] = cap_wdata;
      cyc = cyc + 1;
      #1;
      bus.mem_valid = spur;
      bus.mem_rdata = spur ? 16'($urandom) : 16'h0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         bus.mem_valid = 1'b1;
         bus.mem_rdata = mem_rd(pend[0].addr);
         void'(pend.pop_front());
      end
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_outs(input string tag, input bit en, input bit wr,
                              input logic [15:0] maddr, input logic [15:0] wd,
                              input bit dwe, input bit dtag, input bit iwe, input bit itag,
                              input logic [15:0] fa, input logic [15:0] fd, input bit stl);
      chk({tag, ".mem_en"},    16'(bus.mem_en),    16'(en));
      chk({tag, ".mem_wr"},    16'(bus.mem_wr),    16'(wr));
      if (en) chk({tag, ".mem_addr"}, bus.mem_addr, maddr);
      if (wr) chk({tag, ".mem_wdata"}, bus.mem_wdata, wd);
      chk({tag, ".d_data_we"}, 16'(bus.d_data_we), 16'(dwe));
      chk({tag, ".d_tag_we"},  16'(bus.d_tag_we),  16'(dtag));
      chk({tag, ".i_data_we"}, 16'(bus.i_data_we), 16'(iwe));
      chk({tag, ".i_tag_we"},  16'(bus.i_tag_we),  16'(itag));
      if (dwe || iwe) begin
         chk({tag, ".fill_addr"}, bus.fill_addr, fa);
         chk({tag, ".fill_data"}, bus.fill_data, fd);
      end
      chk({tag, ".stall"},     16'(bus.stall),     16'(stl));
   endtask

   task automatic expect_zero(input string tag);
      expect_outs(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk({tag, ".mem_addr0"},  bus.mem_addr,  16'h0);
      chk({tag, ".fill_addr0"}, bus.fill_addr, 16'h0);
      chk({tag, ".fill_data0"}, bus.fill_data, 16'h0);
   endtask

   // Caller has already raised the miss for the current cycle (cycle 0).
   task automatic do_fill(input bit is_d, input logic [15:0] addr, input int abort_at);
      logic [15:0] base, fa;
      bit en, we, tag;
      base = addr & ~16'(2 * W - 1);
      @(negedge clk);
      expect_outs("fill_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int c = 1; c <= N; c++) begin
         tick();
         if (c == abort_at) begin
            rst = 1'b1;
            bus.d_miss = 1'b0;
            bus.i_miss = 1'b0;
            bus.d_wr   = 1'b0;
            @(negedge clk);
            expect_zero("abort");
            tick();
            rst = 1'b0;
            return;
         end
         // Address movement mid-fill must not disturb the latched base.
         if (c < N) begin
            if (is_d) bus.d_addr = 16'($urandom); else bus.i_addr = 16'($urandom);
         end else begin
            if (is_d) begin bus.d_addr = addr; bus.d_miss = 1'b0; end
            else      begin bus.i_addr = addr; bus.i_miss = 1'b0; end
         end
         en  = (c <= W);
         we  = (c >= L) && (c <= N - 1);
         tag = (c == N - 1);
         fa  = base + 16'(2 * (c - L));
         @(negedge clk);
         expect_outs(is_d ? "fill_d" : "fill_i", en, 0, base + 16'(2 * (c - 1)), 0,
                     is_d && we, is_d && tag, !is_d && we, !is_d && tag,
                     fa, mem_rd(fa), c < N);
      end
   endtask

   // Caller has already raised d_wr for the current cycle (cycle 0).
   task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
      @(negedge clk);
      expect_outs("wr_req", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      @(negedge clk);
      expect_outs("wr", 1, 1, addr, data, 0, 0, 0, 0, 0, 0, 1);
      tick();
      bus.d_wr = 1'b0;
      @(negedge clk);
      expect_outs("wr_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n, input bit spurious);
      for (int k = 0; k < n; k++) begin
         tick();
         spur = spurious ? 1'($urandom) : 1'b0;
         @(negedge clk);
         expect_outs("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
      spur = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a, b, d;
      int kind;
      rst = 1'b1;
      bus.i_miss = 0; bus.i_addr = 0; bus.d_miss = 0; bus.d_addr = 0;
      bus.d_wr = 0; bus.d_wdata = 0; bus.mem_valid = 0; bus.mem_rdata = 0;
      repeat (2) @(negedge clk);
      expect_zero("reset");
      tick();
      rst = 1'b0;
      idle(1, 0);

      // I-miss fill of the 0x0030 block
      tick(); bus.i_miss = 1; bus.i_addr = 16'h0036;
      do_fill(0, 16'h0036, 0);
      idle(1, 0);

      // write-through store
      tick(); bus.d_wr = 1; bus.d_addr = 16'h1002; bus.d_wdata = 16'hBEEF;
      do_write(16'h1002, 16'hBEEF);
      idle(1, 0);

      // D and I miss together: D first, then I
      tick(); bus.d_miss = 1; bus.d_addr = 16'h2000; bus.i_miss = 1; bus.i_addr = 16'h0010;
      do_fill(1, 16'h2000, 0);
      tick();
      do_fill(0, 16'h0010, 0);
      idle(1, 0);

      // reset in cycle 5 of a fill; late read data must be ignored
      tick(); bus.d_miss = 1; bus.d_addr = 16'h4444;
      do_fill(1, 16'h4444, 5);
      idle(8, 0);

      // spurious mem_valid while idle
      idle(6, 1);

      // top-of-memory block
      tick(); bus.d_miss = 1; bus.d_addr = 16'hFFF8;
      do_fill(1, 16'hFFF8, 0);
      idle(1, 0);

      // store miss: fill first, then the store goes out
      tick(); bus.d_miss = 1; bus.d_wr = 1; bus.d_addr = 16'h3006; bus.d_wdata = 16'h1234;
      do_fill(1, 16'h3006, 0);
      tick();
      do_write(16'h3006, 16'h1234);
      idle(1, 0);

      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 5);
         a = 16'($urandom); b = 16'($urandom); d = 16'($urandom);
         tick();
         case (kind)
            0: begin bus.i_miss = 1; bus.i_addr = a; do_fill(0, a, 0); end
            1: begin bus.d_miss = 1; bus.d_addr = a; do_fill(1, a, 0); end
            2: begin bus.d_wr = 1; bus.d_addr = a; bus.d_wdata = d; do_write(a, d); end
            3: begin
               bus.d_miss = 1; bus.d_addr = a; bus.i_miss = 1; bus.i_addr = b;
               do_fill(1, a, 0);
               tick();
               do_fill(0, b, 0);
            end
            4: begin
               bus.d_miss = 1; bus.d_wr = 1; bus.d_addr = a; bus.d_wdata = d;
               do_fill(1, a, 0);
               tick();
               do_write(a, d);
            end
            default: begin
               if (b[0]) begin bus.d_miss = 1; bus.d_addr = a; end
               else      begin bus.i_miss = 1; bus.i_addr = a; end
               do_fill(b[0], a, $urandom_range(1, N - 1));
               idle(4, 0);
            end
         endcase
         idle($urandom_range(1, 3), 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
